// File: rtl/interrupt_controller.sv
// Interrupt factor/mask registers with a fixed-priority, one-hot request vector.
// K-port pins pass through a 2-flop synchronizer and an edge detector.
module interrupt_controller #(
    parameter logic [11:0] FACTOR_BASE = 12'hF00,
    parameter logic [11:0] MASK_BASE   = 12'hF10,
    parameter logic [23:0] VEC_LINES   = {4'd11, 4'd9, 4'd7, 4'd5, 4'd3, 4'd1}
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] event_pulse,
    input  logic [3:0]  k0_pin,
    input  logic [3:0]  k1_pin,
    input  logic [7:0]  k_edge_sel,
    input  logic [11:0] bus_addr,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [3:0]  bus_wdata,
    output logic [3:0]  bus_rdata,
    output logic        bus_rdata_valid,
    output logic [14:0] interrupt_req
);

    logic [3:0]  factor [6];
    logic [3:0]  mask   [6];
    logic [7:0]  k_meta;
    logic [7:0]  k_sync;
    logic [7:0]  k_prev;
    logic [1:0]  warm;
    logic [7:0]  k_rise;
    logic [7:0]  k_fall;
    logic [7:0]  k_hit;
    logic [23:0] set_bits;
    logic [5:0]  fac_sel;
    logic [5:0]  msk_sel;
    logic [5:0]  pend;
    logic        rd_hit;
    logic [3:0]  rd_val;
    logic [14:0] req_next;

    // Sync and prev flops need three edges to agree after reset.
    assign k_rise   = k_sync & ~k_prev;
    assign k_fall   = ~k_sync & k_prev;
    assign k_hit    = (warm == 2'd3) ?
                      ((k_rise & k_edge_sel) | (k_fall & ~k_edge_sel)) : 8'h00;
    assign set_bits = {k_hit, event_pulse};

    always_comb begin
        fac_sel  = '0;
        msk_sel  = '0;
        pend     = '0;
        rd_val   = 4'h0;
        req_next = '0;
        for (int g = 0; g < 6; g++) begin
            fac_sel[g] = (bus_addr == FACTOR_BASE + 12'(g));
            msk_sel[g] = (bus_addr == MASK_BASE + 12'(g));
            if (fac_sel[g]) rd_val = factor[g];
            if (msk_sel[g]) rd_val = mask[g];
            pend[g] = |(factor[g] & mask[g]);
            // Ascending scan: the highest pending group wins.
            if (pend[g]) req_next = 15'd1 << VEC_LINES[4*g +: 4];
        end
        rd_hit = bus_read && ((|fac_sel) || (|msk_sel));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < 6; g++) begin
                factor[g] <= 4'h0;
                mask[g]   <= 4'h0;
            end
            k_meta          <= '0;
            k_sync          <= '0;
            k_prev          <= '0;
            warm            <= '0;
            bus_rdata       <= 4'h0;
            bus_rdata_valid <= 1'b0;
            interrupt_req   <= '0;
        end else begin
            k_meta <= {k1_pin, k0_pin};
            k_sync <= k_meta;
            k_prev <= k_sync;
            if (warm != 2'd3) warm <= warm + 2'd1;
            for (int g = 0; g < 6; g++) begin
                factor[g] <= ((bus_read && fac_sel[g]) ? 4'h0 : factor[g])
                             | set_bits[4*g +: 4];
                if (bus_write && msk_sel[g]) mask[g] <= bus_wdata;
            end
            bus_rdata_valid <= rd_hit;
            if (rd_hit) bus_rdata <= rd_val;
            interrupt_req <= req_next;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus randomized traffic for interrupt_controller,
// compared against a register-level reference model.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] event_pulse;
    logic [3:0]  k0_pin;
    logic [3:0]  k1_pin;
    logic [7:0]  k_edge_sel;
    logic [11:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_wdata;
    logic [3:0]  bus_rdata;
    logic        bus_rdata_valid;
    logic [14:0] interrupt_req;

    int checks = 0;
    int fails  = 0;

    interrupt_controller dut (
        .clk(clk), .reset_n(reset_n), .event_pulse(event_pulse),
        .k0_pin(k0_pin), .k1_pin(k1_pin), .k_edge_sel(k_edge_sel),
        .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_rdata_valid(bus_rdata_valid), .interrupt_req(interrupt_req)
    );

    always #5 clk = ~clk;

    // Reference model: flags, masks, and pin levels seen at past edges.
    logic [3:0]  mf [6];
    logic [3:0]  mm [6];
    logic [14:0] m_req;
    logic [3:0]  m_rd;
    logic        m_val;
    logic [7:0]  h1, h2, h3;
    int          m_edges;

    function automatic logic [14:0] model_req();
        for (int g = 5; g >= 0; g--)
            if ((mf[g] & mm[g]) != 4'h0) return 15'(1) << (2 * g + 1);
        return '0;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 6; g++) begin
            mf[g] = 4'h0;
            mm[g] = 4'h0;
        end
        m_req = '0; m_rd = 4'h0; m_val = 1'b0;
        h1 = '0; h2 = '0; h3 = '0;
        m_edges = 0;
    endtask

    task automatic model_step();
        logic [14:0] nreq;
        logic [7:0]  kset;
        int          a;
        nreq = model_req();
        kset = '0;
        // A pin level change becomes visible as a flag 3 clocks later.
        if (m_edges >= 3)
            for (int p = 0; p < 8; p++)
                if (h2[p] != h3[p] && h2[p] == k_edge_sel[p]) kset[p] = 1'b1;
        a = int'(bus_addr) - 'hF00;
        m_val = 1'b0;
        if (bus_read && a >= 0 && a < 6) begin
            m_rd = mf[a]; m_val = 1'b1; mf[a] = 4'h0;
        end else if (bus_read && a >= 16 && a < 22) begin
            m_rd = mm[a - 16]; m_val = 1'b1;
        end
        if (bus_write && a >= 16 && a < 22) mm[a - 16] = bus_wdata;
        for (int g = 0; g < 4; g++) mf[g] = mf[g] | event_pulse[4*g +: 4];
        mf[4] = mf[4] | kset[3:0];
        mf[5] = mf[5] | kset[7:4];
        m_req = nreq;
        h3 = h2; h2 = h1; h1 = {k1_pin, k0_pin};
        m_edges++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        event_pulse = '0;
        bus_read    = 1'b0;
        bus_write   = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [3:0] data);
        bus_addr = addr; bus_write = 1'b1; bus_wdata = data;
        tick();
    endtask

    task automatic rd(input logic [11:0] addr);
        bus_addr = addr; bus_read = 1'b1;
        tick();
    endtask

    task automatic pulse(input int b);
        event_pulse[b] = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        if (interrupt_req !== 15'h0) begin fails++; $display("FAIL reset_req: got %h want 0", interrupt_req); end
        checks++;
        if (bus_rdata !== 4'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", bus_rdata); end
        checks++;
        if (bus_rdata_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus_rdata_valid); end
        checks++;
    endtask

    task automatic test_basic();
        wr(12'hF12, 4'h1);
        pulse(8);
        tick();
        if (interrupt_req !== 15'h0020) begin fails++; $display("FAIL basic_req: got %h want 0020", interrupt_req); end
        checks++;
        rd(12'hF02);
        if (bus_rdata !== 4'h1 || bus_rdata_valid !== 1'b1) begin
            fails++; $display("FAIL basic_read: got %h/%b want 1/1", bus_rdata, bus_rdata_valid);
        end
        checks++;
        tick();
        if (interrupt_req !== 15'h0) begin fails++; $display("FAIL basic_clear: got %h want 0", interrupt_req); end
        checks++;
        rd(12'hF02);
        if (bus_rdata !== 4'h0) begin fails++; $display("FAIL basic_reread: got %h want 0", bus_rdata); end
        checks++;
    endtask

    task automatic test_priority();
        for (int g = 0; g < 6; g++) wr(12'hF10 + 12'(g), 4'hF);
        pulse(0);
        tick();
        if (interrupt_req !== 15'h0002) begin fails++; $display("FAIL prio_low: got %h want 0002", interrupt_req); end
        checks++;
        pulse(12);
        tick();
        if (interrupt_req !== 15'h0080) begin fails++; $display("FAIL prio_high: got %h want 0080", interrupt_req); end
        checks++;
        rd(12'hF03);
        tick();
        if (interrupt_req !== 15'h0002) begin fails++; $display("FAIL prio_back: got %h want 0002", interrupt_req); end
        checks++;
        rd(12'hF00);
        tick();
    endtask

    task automatic test_kpin();
        k_edge_sel = 8'h00;
        k1_pin = 4'hF;
        repeat (4) tick();
        rd(12'hF05);
        if (bus_rdata !== 4'h0) begin fails++; $display("FAIL kpin_rise_ign: got %h want 0", bus_rdata); end
        checks++;
        wr(12'hF15, 4'h4);
        k1_pin[2] = 1'b0;
        repeat (3) tick();
        if (interrupt_req !== 15'h0) begin fails++; $display("FAIL kpin_early: got %h want 0", interrupt_req); end
        checks++;
        tick();
        if (interrupt_req !== 15'h0800) begin fails++; $display("FAIL kpin_req: got %h want 0800", interrupt_req); end
        checks++;
        rd(12'hF05);
        if (bus_rdata !== 4'h4) begin fails++; $display("FAIL kpin_flag: got %h want 4", bus_rdata); end
        checks++;
        k1_pin[2] = 1'b1;
        repeat (5) tick();
        rd(12'hF05);
        if (bus_rdata !== 4'h0) begin fails++; $display("FAIL kpin_rise: got %h want 0", bus_rdata); end
        checks++;
    endtask

    task automatic test_read_set_collision();
        pulse(4);
        event_pulse[5] = 1'b1;
        rd(12'hF01);
        if (bus_rdata !== 4'h1) begin fails++; $display("FAIL coll_old: got %h want 1", bus_rdata); end
        checks++;
        rd(12'hF01);
        if (bus_rdata !== 4'h2) begin fails++; $display("FAIL coll_kept: got %h want 2", bus_rdata); end
        checks++;
    endtask

    task automatic test_mask();
        wr(12'hF10, 4'h0);
        pulse(1);
        tick();
        if (interrupt_req !== 15'h0) begin fails++; $display("FAIL mask_hold: got %h want 0", interrupt_req); end
        checks++;
        wr(12'hF10, 4'h2);
        if (interrupt_req !== 15'h0) begin fails++; $display("FAIL mask_lat: got %h want 0", interrupt_req); end
        checks++;
        tick();
        if (interrupt_req !== 15'h0002) begin fails++; $display("FAIL mask_open: got %h want 0002", interrupt_req); end
        checks++;
        wr(12'hF10, 4'h0);
        tick();
        if (interrupt_req !== 15'h0) begin fails++; $display("FAIL mask_drop: got %h want 0", interrupt_req); end
        checks++;
        rd(12'hF00);
        if (bus_rdata !== 4'h2) begin fails++; $display("FAIL mask_retain: got %h want 2", bus_rdata); end
        checks++;
    endtask

    task automatic test_async_reset();
        k_edge_sel[3:0] = 4'hF;
        wr(12'hF14, 4'hF);
        k0_pin[0] = 1'b1;
        repeat (4) tick();
        if (interrupt_req !== 15'h0200) begin fails++; $display("FAIL ares_pre: got %h want 0200", interrupt_req); end
        checks++;
        #3 reset_n = 1'b0;
        #1;
        if (interrupt_req !== 15'h0 || bus_rdata_valid !== 1'b0) begin
            fails++; $display("FAIL ares_now: got %h/%b want 0/0", interrupt_req, bus_rdata_valid);
        end
        checks++;
        model_reset();
        k0_pin = 4'hF;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) tick();
        wr(12'hF14, 4'hF);
        repeat (2) tick();
        if (interrupt_req !== 15'h0) begin fails++; $display("FAIL ares_spur: got %h want 0", interrupt_req); end
        checks++;
        rd(12'hF04);
        if (bus_rdata !== 4'h0 || bus_rdata_valid !== 1'b1) begin
            fails++; $display("FAIL ares_flag: got %h/%b want 0/1", bus_rdata, bus_rdata_valid);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [7:0] p;
        int         r;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) event_pulse = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) begin
                p = {k1_pin, k0_pin} ^ (8'(1) << $urandom_range(0, 7));
                {k1_pin, k0_pin} = p;
            end
            if ($urandom_range(0, 60) == 0) k_edge_sel = 8'($urandom);
            case ($urandom_range(0, 3))
                0: bus_addr = 12'hF00 + 12'($urandom_range(0, 7));
                1: bus_addr = 12'hF10 + 12'($urandom_range(0, 7));
                2: bus_addr = 12'($urandom);
                default: bus_addr = 12'hF00 + 12'($urandom_range(0, 5));
            endcase
            r = $urandom_range(0, 9);
            bus_read  = (r <= 2 || r == 5);
            bus_write = (r == 3 || r == 4 || r == 5);
            bus_wdata = 4'($urandom);
            tick();
            if (interrupt_req !== m_req) begin
                fails++; $display("FAIL rnd_req[%0d]: got %h want %h", i, interrupt_req, m_req);
            end
            checks++;
            if (bus_rdata_valid !== m_val) begin
                fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus_rdata_valid, m_val);
            end
            checks++;
            if (bus_rdata !== m_rd) begin
                fails++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, bus_rdata, m_rd);
            end
            checks++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        event_pulse = '0;
        k0_pin = '0;
        k1_pin = '0;
        k_edge_sel = '0;
        bus_addr = '0;
        bus_read = 1'b0;
        bus_write = 1'b0;
        bus_wdata = '0;
        #2;
        test_reset();
        test_basic();
        test_priority();
        test_kpin();
        test_read_set_collision();
        test_mask();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
